// File: rtl/uart_defs.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_defs (package)
// Purpose  : Shared UART state encoding, frame constants and width helper.
//            Frame layout follows macro UART_TX_PARITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
package uart_defs;

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_START  = 3'd1;
    localparam logic [2:0] c_ST_DATA   = 3'd2;
    localparam logic [2:0] c_ST_PARITY = 3'd3;
    localparam logic [2:0] c_ST_STOP   = 3'd4;

`ifdef UART_TX_PARITY_EN
    localparam int         c_FRAME_BITS     = 11;
    localparam logic [2:0] c_ST_AFTER_DATA  = c_ST_PARITY;
`else
    localparam int         c_FRAME_BITS     = 10;
    localparam logic [2:0] c_ST_AFTER_DATA  = c_ST_STOP;
`endif

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_sync_fifo
// Purpose  : Single-clock FIFO with ready/valid push, pop strobe and count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sync_fifo
    import uart_defs::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_valid,
    output logic                          push_ready,
    input  logic [WIDTH-1:0]              push_data,
    input  logic                          pop,
    output logic [WIDTH-1:0]              pop_data,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          empty
);

    localparam int                c_PTR_W = $clog2(DEPTH);
    localparam int                c_CNT_W = count_width(DEPTH);
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_push;
    logic               w_pop;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign push_ready = (r_count != c_FULL);
    assign empty      = (r_count == '0);
    assign count      = r_count;
    assign pop_data   = r_mem[r_rd_ptr];
    assign w_push     = push_valid && push_ready;
    assign w_pop      = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered 8N1 UART transmitter; UART_TX_PARITY_EN adds even parity.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter int CLOCK_FREQ = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         data_in,
    input  logic                               data_in_valid,
    output logic                               data_in_ready,
    output logic                               serial_out,
    output logic                               tx_busy,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);

    localparam int                 c_SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int                 c_CNT_W  = (c_SYMBOL_EDGE_TIME > 1) ? $clog2(c_SYMBOL_EDGE_TIME) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(c_SYMBOL_EDGE_TIME - 1);

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [c_CNT_W-1:0]      r_baud_cnt;
    logic [2:0]              r_bit_idx;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic                    r_tx;
    logic                    w_bit_done;
    logic                    w_pop;
    logic                    w_fifo_empty;
    logic [7:0]              w_head;
    logic [c_FRAME_BITS-1:0] w_frame;

    uart_tx_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (data_in_valid),
        .push_ready (data_in_ready),
        .push_data  (data_in),
        .pop        (w_pop),
        .pop_data   (w_head),
        .count      (fifo_count),
        .empty      (w_fifo_empty)
    );

`ifdef UART_TX_PARITY_EN
    assign w_frame = {1'b1, ^w_head, w_head, 1'b0};
`else
    assign w_frame = {1'b1, w_head, 1'b0};
`endif

    assign w_bit_done = (r_baud_cnt == c_CNT_MAX);
    assign serial_out = r_tx;
    assign tx_busy    = (r_state != c_ST_IDLE) || !w_fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = c_ST_START;
                end
            end
            c_ST_START: begin
                if (w_bit_done) begin
                    w_state_next = c_ST_DATA;
                end
            end
            c_ST_DATA: begin
                if (w_bit_done && (r_bit_idx == 3'd7)) begin
                    w_state_next = c_ST_AFTER_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            c_ST_PARITY: begin
                if (w_bit_done) begin
                    w_state_next = c_ST_STOP;
                end
            end
`endif
            c_ST_STOP: begin
                // Chain straight into the next start bit to keep frames gapless.
                if (w_bit_done) begin
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = c_ST_START;
                    end else begin
                        w_state_next = c_ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // r_tx always mirrors the bit on the line; r_shift[1] is the next one due.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx       <= 1'b1;
            r_shift    <= '1;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (w_pop) begin
            r_tx       <= 1'b0;
            r_shift    <= w_frame;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
        end else if (r_state == c_ST_IDLE) begin
            r_tx       <= 1'b1;
            r_baud_cnt <= '0;
        end else if (w_bit_done) begin
            r_tx       <= r_shift[1];
            r_shift    <= {1'b1, r_shift[c_FRAME_BITS-1:1]};
            r_baud_cnt <= '0;
            if (r_state == c_ST_DATA) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end else begin
            r_baud_cnt <= r_baud_cnt + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Purpose  : Scoreboard bench: stimulus queues expected frames, a line monitor decodes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;
    import uart_defs::*;

    localparam int c_CLOCK_FREQ = 50_000_000;
    localparam int c_BAUD       = 115_200;
    localparam int c_DEPTH      = 8;
    localparam int c_SET        = 434;
    localparam int c_NBITS      = c_FRAME_BITS;
    localparam int c_FRAME      = c_NBITS * c_SET;
    localparam int c_CW         = count_width(c_DEPTH);

    typedef struct {
        logic [7:0] data;
        bit         b2b;
    } exp_t;

    exp_t exp_q[$];

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      data_in = 8'h00;
    logic            data_in_valid = 1'b0;
    logic            data_in_ready;
    logic            serial_out;
    logic            tx_busy;
    logic [c_CW-1:0] fifo_count;

    int n_checks  = 0;
    int n_errors  = 0;
    int cyc       = 0;
    int abort_req = 0;

    uart_tx_fifo #(
        .CLOCK_FREQ (c_CLOCK_FREQ),
        .BAUD_RATE  (c_BAUD),
        .FIFO_DEPTH (c_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .serial_out    (serial_out),
        .tx_busy       (tx_busy),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Line monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial begin : monitor
        logic [c_NBITS-1:0] bits;
        int   t_start;
        int   prev_start;
        int   abort_seen;
        exp_t item;
        prev_start = -1000000;
        abort_seen = 0;
        forever begin
            @(negedge clk);
            if (!rst && serial_out === 1'b0) begin
                t_start = cyc;
                for (int b = 0; b < c_NBITS; b++) begin
                    repeat ((b == 0) ? (c_SET / 2 - 1) : c_SET) @(negedge clk);
                    bits[b] = serial_out;
                end
                if (abort_req != abort_seen) begin
                    abort_seen = abort_req;
                    exp_q.delete();
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_frame", 1, 0);
                end else begin
                    item = exp_q.pop_front();
                    chk("start_bit", int'(bits[0]), 0);
                    chk("data_byte", int'(bits[8:1]), int'(item.data));
`ifdef UART_TX_PARITY_EN
                    chk("parity_bit", int'(bits[9]), int'(^item.data));
`endif
                    chk("stop_bit", int'(bits[c_NBITS-1]), 1);
                    if (item.b2b) begin
                        chk("b2b_gap", t_start - prev_start, c_FRAME);
                    end
                end
                prev_start = t_start;
            end
        end
    end

    task automatic push_byte(input logic [7:0] b, input bit b2b);
        exp_t e;
        @(negedge clk);
        data_in       = b;
        data_in_valid = 1'b1;
        e.data = b;
        e.b2b  = b2b;
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    // Single byte into an idle transmitter: latency and frame length.
    task automatic single_frame(input logic [7:0] b);
        push_byte(b, 1'b0);
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("sf_count_after_push", int'(fifo_count), 1);
        chk("sf_line_before_pop", int'(serial_out), 1);
        @(negedge clk);
        chk("sf_line_start", int'(serial_out), 0);
        chk("sf_count_after_pop", int'(fifo_count), 0);
        chk("sf_busy_start", int'(tx_busy), 1);
        repeat (c_FRAME - 1) @(negedge clk);
        chk("sf_busy_last", int'(tx_busy), 1);
        @(negedge clk);
        chk("sf_busy_drop", int'(tx_busy), 0);
        chk("sf_line_idle", int'(serial_out), 1);
        repeat (20) @(negedge clk);
        chk("sf_scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin : stim
        int bad;
        int waited;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_serial_out", int'(serial_out), 1);
        chk("rst_ready", int'(data_in_ready), 1);
        chk("rst_busy", int'(tx_busy), 0);
        chk("rst_count", int'(fifo_count), 0);
        rst = 1'b0;

        bad = 0;
        repeat (1000) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || data_in_ready !== 1'b1 || tx_busy !== 1'b0 || fifo_count !== '0)
                bad++;
        end
        chk("idle_stable", bad, 0);

        single_frame(8'hA5);
`ifdef UART_TX_PARITY_EN
        single_frame(8'h07);
`endif

        // Burst of 9: byte 0 pops at once, bytes 1..8 fill the FIFO.
        for (int i = 0; i < 9; i++) begin
            push_byte(8'(i), i != 0);
        end
        @(negedge clk);
        data_in = 8'hFF;
        chk("burst_full_count", int'(fifo_count), 8);
        chk("burst_full_ready", int'(data_in_ready), 0);

        bad    = 0;
        waited = 0;
        while (!data_in_ready && waited < 6000) begin
            @(negedge clk);
            waited++;
            if (!data_in_ready && fifo_count != c_CW'(8)) bad++;
        end
        chk("full_count_hold", bad, 0);
        chk("ready_return_cycle", waited, c_FRAME - 7);
        chk("count_after_free", int'(fifo_count), 7);
        begin
            exp_t e;
            e.data = 8'hFF;
            e.b2b  = 1'b1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        data_in_valid = 1'b0;
        chk("held_byte_captured", int'(fifo_count), 8);

        waited = 0;
        while ((exp_q.size() != 0 || tx_busy) && waited < 50000) begin
            @(negedge clk);
            waited++;
        end
        chk("burst_drain_in_time", int'(waited < 50000), 1);
        repeat (50) @(negedge clk);

        // Reset in the middle of the second frame's data bits.
        push_byte(8'h11, 1'b0);
        push_byte(8'h22, 1'b1);
        push_byte(8'h33, 1'b1);
        @(negedge clk);
        data_in_valid = 1'b0;
        repeat (c_FRAME + 5 * c_SET - 1) @(negedge clk);
        abort_req++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_line_high", int'(serial_out), 1);
        chk("abort_count", int'(fifo_count), 0);
        chk("abort_busy", int'(tx_busy), 0);
        chk("abort_ready", int'(data_in_ready), 1);
        bad = 0;
        repeat (3 * c_FRAME) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("abort_no_restart", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        repeat (98000) @(posedge clk);
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter. It is the transmit-direction counterpart of the on-chip UART receive path and drives FPGA_SERIAL_TX. The CPU's memory-mapped IO store path pushes bytes into an internal FIFO through a ready/valid handshake. A baud-timed state machine serializes each byte as 8N1, LSB first, so software can queue several bytes without polling per bit.

Parameters:
- CLOCK_FREQ, 50_000_000, core clock frequency in Hz.
- BAUD_RATE, 115_200, serial bit rate.
- FIFO_DEPTH, 8, entries in the byte FIFO; must be a power of 2, minimum 2.

Ports:
- clk  input  1  core clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  8  byte to enqueue.
- data_in_valid  input  1  producer offers data_in this cycle.
- data_in_ready  output  1  FIFO can accept a byte this cycle.
- serial_out  output  1  UART line to the level shifter; idle high.
- tx_busy  output  1  high while a frame is on the line or the FIFO is non-empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: serial_out=1, data_in_ready=1, tx_busy=0, fifo_count=0, FSM=IDLE, baud counter=0, FIFO pointers=0. Asserting rst mid-frame aborts the frame and flushes the FIFO. The line returns high on the cycle after the reset edge, and no partial byte is resumed.
- Push: when data_in_valid && data_in_ready at a rising edge, the byte is written and fifo_count increments.
- data_in_ready = (fifo_count != FIFO_DEPTH). When full, valid is ignored and the byte is not captured. A push is refused while full even if a pop occurs in the same cycle.
- Simultaneous push and pop with the FIFO not full: fifo_count is unchanged and both operations take effect.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally; full/empty are derived from fifo_count.
- SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE, integer-truncated (434 at defaults). The baud counter runs 0..SYMBOL_EDGE_TIME-1 and clears at each bit boundary and on FSM entry to START.
- FSM:
  - IDLE: serial_out=1. If FIFO non-empty, pop the head into a 10-bit shift register {1, byte, 0} and go to START.
  - START/DATA/STOP: each bit is held for exactly SYMBOL_EDGE_TIME cycles. There are 8 DATA bits, LSB first, counted by a 3-bit index.
  - After STOP: if the FIFO is non-empty, pop and go directly to START, so frames are back-to-back with no idle gap. Otherwise go to IDLE.
- Latency: a byte accepted at edge E into an empty FIFO with the FSM in IDLE is popped at edge E+1, and serial_out goes low after edge E+1.
- Frame length is 10*SYMBOL_EDGE_TIME cycles.
- tx_busy = (FSM != IDLE) || (fifo_count != 0).
- serial_out is driven from a register, never from combinational logic.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state between the last DATA bit and STOP transmits even parity (XOR of the 8 data bits). Frame length becomes 11*SYMBOL_EDGE_TIME and the shift register is 11 bits.
- Undefined: pure 8N1 as above, and no parity logic is synthesized.

Decomposition:
- Shared package uart_defs:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP).
  - Frame-length constants.
  - A clog2-based width helper reused by the receive side.
- One sub-module, uart_tx_sync_fifo: synchronous FIFO with push/pop/count, parameterized by DEPTH and WIDTH=8.
- The FSM, baud counter and shift register stay in uart_tx_fifo.

Test Plan:
- Reset then idle 1000 cycles -> serial_out=1, data_in_ready=1, tx_busy=0, fifo_count=0 throughout.
- Push 0xA5 once at defaults -> serial_out low after edge E+1. Line sampled mid-bit every 434 cycles gives 0,1,0,1,0,0,1,0,1,1. tx_busy drops 4340 cycles after the start bit.
- Push 9 bytes (0x00..0x08) on consecutive cycles with the FSM idle -> byte 0 pops immediately and bytes 1..8 fill the FIFO (fifo_count=8). data_in_ready=0 until the next pop frees an entry. All 9 frames appear back-to-back with no idle gap, in order.
- Hold data_in_valid with 0xFF while the FIFO is full -> no capture, fifo_count stays 8, and the byte is written on the first cycle ready returns.
- Assert rst for 1 cycle at mid-DATA of frame 2 -> serial_out=1 after the reset edge, fifo_count=0, and no further start bits appear.
- With UART_TX_PARITY_EN, push 0x07 -> parity bit=1 after the 8 data bits, then stop bit, frame 4774 cycles.
